dual_port_ram_be: RTL

//  Parametrised true dual-port RAM, next generation of the project's

---
 rtl/dual_port_ram_be.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte-lane writes, read-during-write mode select, collision
// arbitration and a clear sweep. Define DPRAM_OUTREG_EN for an extra output register stage.
module dual_port_ram_be #(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   AW       = 6,
  parameter int unsigned   RDW_MODE = 0,
  parameter logic [DW-1:0] CLR_VAL  = '0
) (
  input  logic            C,
  input  logic            nRST,
  input  logic            CLR,
  output logic            BUSY,
  output logic            COLL,
  input  logic            aEN,
  input  logic            aWR,
  input  logic [DW/8-1:0] aBE,
  input  logic [AW-1:0]   aA,
  input  logic [DW-1:0]   aD,
  output logic [DW-1:0]   aQ,
  output logic            aV,
  input  logic            bEN,
  input  logic            bWR,
  input  logic [DW/8-1:0] bBE,
  input  logic [AW-1:0]   bA,
  input  logic [DW-1:0]   bD,
  output logic [DW-1:0]   bQ,
  output logic            bV
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {StClear, StIdle} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_idle;
  logic          w_a_acc, w_b_acc, w_a_we, w_b_we, w_same, w_coll;
  logic [DW-1:0] w_a_old, w_b_old, w_a_new, w_b_new, w_a_rdata, w_b_rdata;

  logic [DW-1:0] r_aq, r_bq;
  logic          r_av, r_bv, r_coll;

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StClear: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (&r_cnt) w_state_nxt = StIdle;
      end
      StIdle: begin
        if (CLR) begin
          w_state_nxt = StClear;
          w_cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign BUSY    = (r_state == StClear);
  assign w_idle  = (r_state == StIdle);
  assign w_a_acc = w_idle & aEN;
  assign w_b_acc = w_idle & bEN;
  assign w_a_we  = w_a_acc & aWR;
  assign w_b_we  = w_b_acc & bWR;
  assign w_same  = (aA == bA);
  assign w_coll  = w_a_acc & w_b_acc & w_same & (w_a_we | w_b_we);

  assign w_a_old = r_mem[aA];
  assign w_b_old = r_mem[bA];

  // Resulting word at each port's address; on a shared address both views are identical
  // and port A owns any lane enabled by both writers.
  always_comb begin
    w_a_new = w_a_old;
    w_b_new = w_b_old;
    for (int i = 0; i < NB; i++) begin
      if (w_a_we && aBE[i]) begin
        w_a_new[8*i +: 8] = aD[8*i +: 8];
      end else if (w_b_we && bBE[i] && w_same) begin
        w_a_new[8*i +: 8] = bD[8*i +: 8];
      end
      if (w_a_we && aBE[i] && w_same) begin
        w_b_new[8*i +: 8] = aD[8*i +: 8];
      end else if (w_b_we && bBE[i]) begin
        w_b_new[8*i +: 8] = bD[8*i +: 8];
      end
    end
  end

  assign w_a_rdata = (aWR && (RDW_MODE == 0)) ? w_a_new : w_a_old;
  assign w_b_rdata = (bWR && (RDW_MODE == 0)) ? w_b_new : w_b_old;

  always_ff @(posedge C) begin
    if (!w_idle) begin
      r_mem[r_cnt] <= CLR_VAL;
    end else begin
      if (w_b_we) r_mem[bA] <= w_b_new;
      if (w_a_we) r_mem[aA] <= w_a_new;
    end
  end

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_aq   <= '0;
      r_bq   <= '0;
      r_av   <= 1'b0;
      r_bv   <= 1'b0;
      r_coll <= 1'b0;
    end else begin
      r_av   <= w_a_acc;
      r_bv   <= w_b_acc;
      r_coll <= w_coll;
      if (w_a_acc) r_aq <= w_a_rdata;
      if (w_b_acc) r_bq <= w_b_rdata;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DW-1:0] r_aq2, r_bq2;
  logic          r_av2, r_bv2, r_coll2;

  always_ff @(posedge C or negedge nRST) begin
    if (!nRST) begin
      r_aq2   <= '0;
      r_bq2   <= '0;
      r_av2   <= 1'b0;
      r_bv2   <= 1'b0;
      r_coll2 <= 1'b0;
    end else begin
      r_aq2   <= r_aq;
      r_bq2   <= r_bq;
      r_av2   <= r_av;
      r_bv2   <= r_bv;
      r_coll2 <= r_coll;
    end
  end

  assign aQ   = r_aq2;
  assign bQ   = r_bq2;
  assign aV   = r_av2;
  assign bV   = r_bv2;
  assign COLL = r_coll2;
`else
  assign aQ   = r_aq;
  assign bQ   = r_bq;
  assign aV   = r_av;
  assign bV   = r_bv;
  assign COLL = r_coll;
`endif

endmodule
